lisnoc_router_output_arbiter: RTL and testbench
===============================================

Name: lisnoc_router_output_arbiter

Overview:
- Per-output-port wormhole arbiter and output register for the lisnoc 2D-grid router.
- Shares one output link between `ports` input requesters using round-robin.
- Locks the grant from a HEAD flit until the matching LAST flit, or for a single SINGLE flit, so packets never interleave.
- Sits between the input buffers/route computation and one `*_out` link; one instance per output direction (north/east/south/west/local), single virtual channel.

Parameters:
- flit_data_width, 32, payload bits per flit.
- flit_width, flit_data_width+2, total flit bits; the top 2 bits are the flit type.
- ports, 5, number of requesting input ports (2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  ports  per-input request: valid flit present, routed to this output.
- flit_i  in  ports*flit_width  per-input flits; input k occupies bits [k*flit_width +: flit_width].
- ready_o  out  ports  per-input accept; a flit transfers from input k when req_i[k] & ready_o[k].
- out_flit_o  out  flit_width  registered output flit.
- out_valid_o  out  1  registered output valid.
- out_ready_i  in  1  downstream accept; transfer when out_valid_o & out_ready_i.
- grant_o  out  ports  one-hot current owner; 0 when idle (debug/statistics).

Behaviour:
- Flit type = flit[flit_width-1:flit_width-2]: 2'b01 HEAD, 2'b00 PAYLOAD, 2'b10 LAST, 2'b11 SINGLE.
- Reset (rst=0, asynchronous):
  - out_valid_o=0, out_flit_o=0, grant_o=0, ready_o=0.
  - State=IDLE, round-robin pointer rr=0 (input 0 has highest priority).
- State IDLE:
  - Candidates are inputs with req_i=1 whose flit type is HEAD or SINGLE. Requests carrying PAYLOAD or LAST are ignored.
  - Choose the first candidate at or after rr, cyclically (rr, rr+1, …, ports-1, 0, …).
  - Arbitration and acceptance of the first flit happen in the same cycle, provided the output stage can load.
- Output stage can load when out_valid_o=0 or out_ready_i=1.
- ready_o[k]=1 only when k is the selected/owner input and the output stage can load. ready_o is combinational from req_i, state and out_ready_i.
- Accepted flit from input k:
  - Load out_flit_o<=flit, out_valid_o<=1. Latency is 1 cycle from acceptance to out_valid_o.
  - If type HEAD: go to BUSY, owner=k, grant_o=onehot(k).
  - If type SINGLE: stay IDLE, set rr<=(k+1) mod ports.
- State BUSY:
  - Only the owner may transfer; all other ready_o=0.
  - Any type is forwarded unchecked.
  - On accepting LAST: go to IDLE, grant_o<=0, rr<=(owner+1) mod ports.
  - An owner with req_i=0 holds the lock; there is no timeout.
- Output register:
  - When out_ready_i=1 and nothing is accepted: out_valid_o<=0.
  - When out_valid_o=1 and out_ready_i=0: out_flit_o and out_valid_o are held stable.
- Throughput: 1 flit/cycle while downstream is ready; no bubble between back-to-back packets from different inputs.
- Simultaneous events: the LAST of one packet and the HEAD of the next cannot be accepted in the same cycle. The next HEAD is accepted no earlier than the following cycle, via IDLE.
- rr wraps from ports-1 to 0. rr updates only on packet completion (LAST or SINGLE accepted).
- Reset asserted mid-packet: the packet is abandoned, the output register is cleared, and arbitration restarts from input 0.

Test Plan:
- Reset:
  - Stimulus: rst=0 with req_i=5'b11111.
  - Required: ready_o=0, out_valid_o=0, grant_o=0.
  - Stimulus: release rst with all inputs presenting SINGLE and out_ready_i=1.
  - Required: inputs are served in order 0,1,2,3,4,0 on consecutive cycles; out_valid_o first rises one cycle after the first acceptance.
- Wormhole lock:
  - Stimulus: input 2 sends HEAD, PAYLOAD, PAYLOAD, LAST (data 0xA0..0xA3); input 0 requests HEAD throughout.
  - Required: out_flit_o shows 0xA0..0xA3 contiguously; grant_o=5'b00100 for the whole packet; input 0 is granted only after LAST.
- Backpressure:
  - Stimulus: during a 4-flit packet from input 1, hold out_ready_i=0 for 3 cycles.
  - Required: out_flit_o/out_valid_o are stable; ready_o[1]=0 after the register fills; no flit is lost or duplicated; output order is preserved.
- Round-robin fairness:
  - Stimulus: inputs 3 and 4 each continuously send 2-flit packets.
  - Required: packets alternate 3,4,3,4; rr wraps 4→0 and the next grant goes to 3.
- Stray flit filtering:
  - Stimulus: in IDLE, input 0 presents PAYLOAD and input 1 presents HEAD.
  - Required: input 1 is granted; ready_o[0]=0.
- Mid-packet reset:
  - Stimulus: assert rst after the second flit of a packet from input 3.
  - Required: outputs clear immediately (asynchronous); after release, input 0 SINGLE is granted first.

Source files
------------

// File: rtl/lisnoc_router_output_arbiter.sv
// ---------------------------------------------------------------------------
// lisnoc_router_output_arbiter
//
// Wormhole output arbiter and output register for one output direction of a
// lisnoc 2D-grid router (single virtual channel). Up to `ports` input buffers
// compete for the link using round-robin arbitration. A HEAD flit locks the
// grant to its input until the matching LAST flit, so packets never
// interleave. A SINGLE flit is a complete one-flit packet.
//
// Flit type (top two bits): 01 HEAD, 00 PAYLOAD, 10 LAST, 11 SINGLE.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   req_i        per-input request (valid flit routed to this output)
//   flit_i       per-input flits, input k at [k*flit_width +: flit_width]
//   ready_o      per-input accept (combinational)
//   out_flit_o   registered output flit
//   out_valid_o  registered output valid
//   out_ready_i  downstream accept
//   grant_o      one-hot owner of the output while a packet is in flight
// ---------------------------------------------------------------------------
module lisnoc_router_output_arbiter #(
    parameter int flit_data_width = 32,
    parameter int flit_width      = flit_data_width + 2,
    parameter int ports           = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ports-1:0]            req_i,
    input  logic [ports*flit_width-1:0] flit_i,
    output logic [ports-1:0]            ready_o,
    output logic [flit_width-1:0]       out_flit_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [ports-1:0]            grant_o
);

    localparam int idx_w = (ports > 1) ? $clog2(ports) : 1;

    // Extended-width constants for the cyclic scan arithmetic.
    localparam logic [idx_w:0] ports_ext = (idx_w + 1)'(ports);
    localparam logic [idx_w:0] last_ext  = (idx_w + 1)'(ports - 1);

    localparam logic [1:0] type_head   = 2'b01;
    localparam logic [1:0] type_last   = 2'b10;
    localparam logic [1:0] type_single = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [idx_w-1:0]        owner_reg, owner_next;
    logic [idx_w-1:0]        rr_reg, rr_next;
    logic [ports-1:0]        grant_reg, grant_next;
    logic [flit_width-1:0]   out_flit_reg, out_flit_next;
    logic                    out_valid_reg, out_valid_next;

    logic [flit_width-1:0]   in_flit [ports];
    logic [ports-1:0]        cand;

    logic                    sel_found;
    logic [idx_w-1:0]        sel_idx;
    logic [idx_w:0]          scan_sum;
    logic [idx_w-1:0]        scan_idx;
    logic [flit_width-1:0]   sel_flit;
    logic [1:0]              sel_type;
    logic                    can_load;
    logic                    accept;

    // Round-robin successor of an input index, wrapping ports-1 -> 0.
    function automatic logic [idx_w-1:0] next_rr(input logic [idx_w-1:0] k);
        if ({1'b0, k} == last_ext) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    // Unpack inputs; only HEAD/SINGLE flits may open a new packet, so stray
    // PAYLOAD/LAST requests never win arbitration while idle.
    for (genvar gi = 0; gi < ports; gi++) begin : g_in
        logic [1:0] in_type;
        assign in_flit[gi] = flit_i[gi*flit_width +: flit_width];
        assign in_type     = in_flit[gi][flit_width-1 -: 2];
        assign cand[gi]    = req_i[gi] &
                             ((in_type == type_head) || (in_type == type_single));
        // Reset gating keeps ready low while rst is asserted even though the
        // selection logic would otherwise see an empty output stage.
        assign ready_o[gi] = rst & accept & (sel_idx == idx_w'(gi));
    end

    // Output stage can take a new flit if empty or being drained this cycle.
    assign can_load = ~out_valid_reg | out_ready_i;

    // Selection: owner while locked, otherwise first candidate at or after rr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (state_reg == BUSY) begin
            sel_idx   = owner_reg;
            sel_found = req_i[owner_reg];
        end else begin
            for (int off = 0; off < ports; off++) begin
                scan_sum = {1'b0, rr_reg} + (idx_w + 1)'(off);
                if (scan_sum >= ports_ext) begin
                    scan_sum = scan_sum - ports_ext;
                end
                scan_idx = scan_sum[idx_w-1:0];
                if (!sel_found && cand[scan_idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = scan_idx;
                end
            end
        end
    end

    assign sel_flit = in_flit[sel_idx];
    assign sel_type = sel_flit[flit_width-1 -: 2];
    assign accept   = sel_found & can_load;

    // Next-state logic.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_next        = rr_reg;
        grant_next     = grant_reg;
        out_flit_next  = out_flit_reg;
        out_valid_next = out_valid_reg;

        if (accept) begin
            out_flit_next  = sel_flit;
            out_valid_next = 1'b1;
            if (state_reg == IDLE) begin
                if (sel_type == type_head) begin
                    state_next = BUSY;
                    owner_next = sel_idx;
                    grant_next = {{(ports-1){1'b0}}, 1'b1} << sel_idx;
                end else begin
                    // SINGLE: packet complete in one flit.
                    rr_next = next_rr(sel_idx);
                end
            end else if (sel_type == type_last) begin
                // Return via IDLE so the next HEAD is taken no earlier than
                // the following cycle.
                state_next = IDLE;
                grant_next = '0;
                rr_next    = next_rr(owner_reg);
            end
        end else if (out_ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_reg        <= '0;
            grant_reg     <= '0;
            out_flit_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_reg        <= rr_next;
            grant_reg     <= grant_next;
            out_flit_reg  <= out_flit_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_flit_o  = out_flit_reg;
    assign out_valid_o = out_valid_reg;
    assign grant_o     = grant_reg;

endmodule

// File: tb/tb_lisnoc_router_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lisnoc_router_output_arbiter
//
// Self-checking bench. Each input k draws flits from a queue of packets; a
// behavioural model (owner index or -1, rr as an integer, output register
// contents) predicts ready_o, grant_o and the output register every cycle.
// Directed phases follow the arbiter's main scenarios, followed by a random
// phase with random request gaps and random downstream backpressure.
// ---------------------------------------------------------------------------
module tb_lisnoc_router_output_arbiter;

    localparam int DW = 32;
    localparam int FW = DW + 2;
    localparam int P  = 5;

    localparam logic [1:0] T_PAY  = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_LAST = 2'b10;
    localparam logic [1:0] T_SING = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [P-1:0]    req_i = '0;
    logic [P*FW-1:0] flit_i = '0;
    logic [P-1:0]    ready_o;
    logic [FW-1:0]   out_flit_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [P-1:0]    grant_o;

    always #5 clk = ~clk;

    lisnoc_router_output_arbiter #(
        .flit_data_width(DW),
        .flit_width     (FW),
        .ports          (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .flit_i     (flit_i),
        .ready_o    (ready_o),
        .out_flit_o (out_flit_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .grant_o    (grant_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int            m_owner;
    int            m_rr;
    bit            m_ov;
    logic [FW-1:0] m_of;

    logic [FW-1:0] src_q [P][$];
    int            acc_log[$];
    logic [31:0]   out_log[$];
    bit            ordy_q[$];
    int            eo[$];
    logic [31:0]   ed[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_ov    = 1'b0;
        m_of    = '0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, advance.
    task automatic step(input bit rnd);
        logic [FW-1:0] f [P];
        bit            rq [P];
        logic [P-1:0]  exp_ready;
        logic [P-1:0]  exp_grant;
        logic [1:0]    t;
        int            pick;
        int            kk;
        int            dacc;
        bit            can;
        bit            ordy;

        if (ordy_q.size() > 0) ordy = ordy_q.pop_front();
        else if (rnd)          ordy = ($urandom_range(0, 3) != 0);
        else                   ordy = 1'b1;

        for (int k = 0; k < P; k++) begin
            rq[k] = (src_q[k].size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
            f[k]  = (src_q[k].size() > 0) ? src_q[k][0] : '0;
            req_i[k] = rq[k];
            flit_i[k*FW +: FW] = f[k];
        end
        out_ready_i = ordy;
        #1;

        // Model prediction.
        can  = !m_ov || ordy;
        pick = -1;
        if (m_owner < 0) begin
            for (int off = 0; off < P; off++) begin
                kk = (m_rr + off) % P;
                t  = f[kk][FW-1 -: 2];
                if (pick < 0 && rq[kk] && (t == T_HEAD || t == T_SING)) pick = kk;
            end
        end else if (rq[m_owner]) begin
            pick = m_owner;
        end
        exp_ready = '0;
        if (pick >= 0 && can) exp_ready[pick] = 1'b1;
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;

        check_val("ready_o", ready_o, exp_ready);
        check_val("out_valid_o", out_valid_o, m_ov);
        check_val("grant_o", grant_o, exp_grant);
        if (m_ov) check_val("out_flit_o", out_flit_o, m_of);

        dacc = -1;
        for (int k = 0; k < P; k++) if (ready_o[k] && req_i[k]) dacc = k;
        if (dacc >= 0) acc_log.push_back(dacc);
        if (out_valid_o && out_ready_i) begin
            out_log.push_back(out_flit_o[DW-1:0]);
            $display("[TB] t=%0t out type=%0d data=%08h grant=%b", $time,
                     out_flit_o[FW-1 -: 2], out_flit_o[DW-1:0], grant_o);
        end

        // Model update.
        if (pick >= 0 && can) begin
            t    = f[pick][FW-1 -: 2];
            m_of = f[pick];
            m_ov = 1'b1;
            if (m_owner < 0) begin
                if (t == T_HEAD) m_owner = pick;
                else             m_rr = (pick + 1) % P;
            end else if (t == T_LAST) begin
                m_rr    = (m_owner + 1) % P;
                m_owner = -1;
            end
            src_q[pick].delete(0);
        end else if (ordy) begin
            m_ov = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    // Step until the masked queues are empty and the output register drained.
    task automatic run(input logic [P-1:0] mask, input bit rnd, input int budget, input string tag);
        int n;
        bit busy;
        n = 0;
        while (1) begin
            busy = m_ov;
            for (int k = 0; k < P; k++) if (mask[k] && src_q[k].size() > 0) busy = 1'b1;
            if (!busy) break;
            if (n >= budget) begin
                check_val({tag, "_drained"}, busy, 0);
                break;
            end
            step(rnd);
            n++;
        end
    endtask

    task automatic check_order(input string tag);
        check_val({tag, "_acc_len"}, acc_log.size(), eo.size());
        for (int i = 0; i < eo.size(); i++)
            check_val($sformatf("%s_acc%0d", tag, i), (i < acc_log.size()) ? acc_log[i] : -1, eo[i]);
    endtask

    task automatic check_data(input string tag);
        check_val({tag, "_out_len"}, out_log.size(), ed.size());
        for (int i = 0; i < ed.size(); i++)
            check_val($sformatf("%s_out%0d", tag, i), (i < out_log.size()) ? out_log[i] : 32'hdead_beef, ed[i]);
    endtask

    initial begin
        int total;
        int len;
        int n;

        // ---------------- Reset with all inputs requesting ----------------
        rst = 1'b0;
        req_i = '1;
        for (int k = 0; k < P; k++) flit_i[k*FW +: FW] = mk(T_SING, 32'(k));
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ready", ready_o, 0);
        check_val("rst_valid", out_valid_o, 0);
        check_val("rst_grant", grant_o, 0);
        check_val("rst_flit", out_flit_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // ---------------- SINGLE flits served round-robin ----------------
        clear_logs();
        src_q[0] = {mk(T_SING, 32'h10), mk(T_SING, 32'h15)};
        src_q[1] = {mk(T_SING, 32'h11), mk(T_SING, 32'h16)};
        src_q[2] = {mk(T_SING, 32'h12)};
        src_q[3] = {mk(T_SING, 32'h13)};
        src_q[4] = {mk(T_SING, 32'h14)};
        run('1, 1'b0, 50, "single");
        eo = {0, 1, 2, 3, 4, 0, 1};
        ed = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
        check_order("single");
        check_data("single");

        // ---------------- Wormhole lock: input 2 vs input 0 ----------------
        clear_logs();
        src_q[2] = {mk(T_HEAD, 32'hA0), mk(T_PAY, 32'hA1), mk(T_PAY, 32'hA2), mk(T_LAST, 32'hA3)};
        src_q[0] = {mk(T_HEAD, 32'hB0), mk(T_LAST, 32'hB1)};
        run('1, 1'b0, 50, "worm");
        eo = {2, 2, 2, 2, 0, 0};
        ed = {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1};
        check_order("worm");
        check_data("worm");

        // ---------------- Backpressure on a 4-flit packet ----------------
        clear_logs();
        src_q[1] = {mk(T_HEAD, 32'hD0), mk(T_PAY, 32'hD1), mk(T_PAY, 32'hD2), mk(T_LAST, 32'hD3)};
        ordy_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run('1, 1'b0, 50, "bp");
        eo = {1, 1, 1, 1};
        ed = {32'hD0, 32'hD1, 32'hD2, 32'hD3};
        check_order("bp");
        check_data("bp");

        // ---------------- Fairness between inputs 3 and 4 ----------------
        clear_logs();
        src_q[3] = {mk(T_HEAD, 32'h30), mk(T_LAST, 32'h31), mk(T_HEAD, 32'h32),
                    mk(T_LAST, 32'h33), mk(T_HEAD, 32'h34), mk(T_LAST, 32'h35)};
        src_q[4] = {mk(T_HEAD, 32'h40), mk(T_LAST, 32'h41), mk(T_HEAD, 32'h42),
                    mk(T_LAST, 32'h43), mk(T_HEAD, 32'h44), mk(T_LAST, 32'h45)};
        run('1, 1'b0, 80, "rr");
        ed = {32'h30, 32'h31, 32'h40, 32'h41, 32'h32, 32'h33,
              32'h42, 32'h43, 32'h34, 32'h35, 32'h44, 32'h45};
        check_data("rr");

        // ---------------- Stray PAYLOAD on input 0 is ignored ----------------
        clear_logs();
        src_q[0] = {mk(T_PAY, 32'h50)};
        src_q[1] = {mk(T_HEAD, 32'h51), mk(T_LAST, 32'h52)};
        run(5'b00010, 1'b0, 30, "stray");
        eo = {1, 1};
        ed = {32'h51, 32'h52};
        check_order("stray");
        check_data("stray");
        check_val("stray_left", src_q[0].size(), 1);
        src_q[0].delete();

        // ---------------- Random traffic with backpressure ----------------
        clear_logs();
        total = 0;
        for (int k = 0; k < P; k++) begin
            for (int p = 0; p < 4; p++) begin
                len = $urandom_range(1, 4);
                total += len;
                if (len == 1) begin
                    src_q[k].push_back(mk(T_SING, $urandom));
                end else begin
                    src_q[k].push_back(mk(T_HEAD, $urandom));
                    for (int i = 0; i < len - 2; i++) src_q[k].push_back(mk(T_PAY, $urandom));
                    src_q[k].push_back(mk(T_LAST, $urandom));
                end
            end
        end
        run('1, 1'b1, 3000, "rand");
        check_val("rand_count", out_log.size(), total);

        // ---------------- Reset in the middle of a packet ----------------
        clear_logs();
        src_q[3] = {mk(T_HEAD, 32'hE0), mk(T_PAY, 32'hE1), mk(T_PAY, 32'hE2), mk(T_LAST, 32'hE3)};
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin
            step(1'b0);
            n++;
        end
        check_val("mid_accepted", acc_log.size(), 2);
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", out_valid_o, 0);
        check_val("mid_rst_grant", grant_o, 0);
        check_val("mid_rst_ready", ready_o, 0);
        check_val("mid_rst_flit", out_flit_o, 0);
        model_reset();
        for (int k = 0; k < P; k++) src_q[k].delete();
        clear_logs();
        @(negedge clk);
        rst = 1'b1;
        src_q[0] = {mk(T_SING, 32'hC0)};
        src_q[3] = {mk(T_SING, 32'hC3)};
        run('1, 1'b0, 30, "after_rst");
        eo = {0, 3};
        ed = {32'hC0, 32'hC3};
        check_order("after_rst");
        check_data("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
